// File: rtl/mem_ctrl_arbiter_if.sv
// Bus bundle between the icache/dcache pair, the memory arbiter and main memory.
// slave is the arbiter's view; master is the caches-plus-memory side.
interface mem_ctrl_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int NUM_TAGS = 16
);
  localparam int TAG_W = $clog2(NUM_TAGS);

  logic [1:0]       icache2ctlr_command;
  logic [XLEN-1:0]  icache2ctlr_addr;
  logic [1:0]       dcache2ctlr_command;
  logic [XLEN-1:0]  dcache2ctlr_addr;
  logic [63:0]      dcache2ctlr_data;

  logic [TAG_W-1:0] Ctlr2icache_response;
  logic [63:0]      Ctlr2icache_data;
  logic [TAG_W-1:0] Ctlr2icache_tag;
  logic [TAG_W-1:0] Ctlr2proc_response;
  logic [63:0]      Ctlr2proc_data;
  logic [TAG_W-1:0] Ctlr2proc_tag;

  logic [1:0]       proc2mem_command;
  logic [XLEN-1:0]  proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [TAG_W-1:0] mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  modport slave (
    input  icache2ctlr_command, icache2ctlr_addr,
    input  dcache2ctlr_command, dcache2ctlr_addr, dcache2ctlr_data,
    output Ctlr2icache_response, Ctlr2icache_data, Ctlr2icache_tag,
    output Ctlr2proc_response, Ctlr2proc_data, Ctlr2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport master (
    output icache2ctlr_command, icache2ctlr_addr,
    output dcache2ctlr_command, dcache2ctlr_addr, dcache2ctlr_data,
    input  Ctlr2icache_response, Ctlr2icache_data, Ctlr2icache_tag,
    input  Ctlr2proc_response, Ctlr2proc_data, Ctlr2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates icache/dcache requests onto single-ported memory, tracks which cache
// owns each outstanding load tag, and steers returned data only to that owner.
module mem_ctrl_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  mem_ctrl_arbiter_if.slave             bus,
  output logic [$clog2(NUM_TAGS+1)-1:0] outstanding_cnt,
  output logic                          orphan_err
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int CNT_W = $clog2(NUM_TAGS+1);
  localparam int SW    = $clog2(STARVE_LIMIT+1);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;

  logic [NUM_TAGS-1:0] valid, valid_nxt;
  logic [NUM_TAGS-1:0] owner_icache, owner_icache_nxt;
  logic [SW-1:0]       starve_cnt, starve_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                orphan_nxt;

  logic                icache_req, dcache_req;
  logic                grant_i, grant_d;
  logic [1:0]          grant_cmd;
  logic                accepted, load_accept;
  logic                ret_valid, ret_hit, ret_to_icache;

  // Grant: dcache wins ties unless icache has lost STARVE_LIMIT times in a row.
  always_comb begin
    icache_req  = (bus.icache2ctlr_command != BUS_NONE);
    dcache_req  = (bus.dcache2ctlr_command != BUS_NONE);
    grant_i     = icache_req && (!dcache_req || (starve_cnt == SW'(STARVE_LIMIT)));
    grant_d     = dcache_req && !grant_i;
    grant_cmd   = grant_i ? bus.icache2ctlr_command :
                  grant_d ? bus.dcache2ctlr_command : BUS_NONE;
    accepted    = (bus.mem2proc_response != '0);
    load_accept = accepted && (grant_cmd == BUS_LOAD);
  end

  always_comb begin
    ret_valid     = (bus.mem2proc_tag != '0);
    ret_hit       = ret_valid && valid[bus.mem2proc_tag];
    ret_to_icache = owner_icache[bus.mem2proc_tag];
  end

  // Outputs are forced quiet while reset is held, independent of the inputs.
  always_comb begin
    bus.proc2mem_command     = BUS_NONE;
    bus.proc2mem_addr        = '0;
    bus.proc2mem_data        = '0;
    bus.Ctlr2icache_response = '0;
    bus.Ctlr2proc_response   = '0;
    bus.Ctlr2icache_tag      = '0;
    bus.Ctlr2icache_data     = '0;
    bus.Ctlr2proc_tag        = '0;
    bus.Ctlr2proc_data       = '0;
    if (reset) begin
      if (grant_i) begin
        bus.proc2mem_command     = bus.icache2ctlr_command;
        bus.proc2mem_addr        = bus.icache2ctlr_addr;
        bus.Ctlr2icache_response = bus.mem2proc_response;
      end else if (grant_d) begin
        bus.proc2mem_command   = bus.dcache2ctlr_command;
        bus.proc2mem_addr      = bus.dcache2ctlr_addr;
        bus.proc2mem_data      = bus.dcache2ctlr_data;
        bus.Ctlr2proc_response = bus.mem2proc_response;
      end
      if (ret_hit) begin
        if (ret_to_icache) begin
          bus.Ctlr2icache_tag  = bus.mem2proc_tag;
          bus.Ctlr2icache_data = bus.mem2proc_data;
        end else begin
          bus.Ctlr2proc_tag  = bus.mem2proc_tag;
          bus.Ctlr2proc_data = bus.mem2proc_data;
        end
      end
    end
  end

  // Return clear goes first so a same-cycle accept on that tag re-owns the entry.
  always_comb begin
    valid_nxt        = valid;
    owner_icache_nxt = owner_icache;
    if (ret_hit)
      valid_nxt[bus.mem2proc_tag] = 1'b0;
    if (load_accept) begin
      valid_nxt[bus.mem2proc_response]        = 1'b1;
      owner_icache_nxt[bus.mem2proc_response] = grant_i;
    end
    cnt_nxt = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      cnt_nxt = cnt_nxt + CNT_W'(valid_nxt[i]);
    orphan_nxt = orphan_err | (ret_valid && !ret_hit);
  end

  // A rejected icache grant keeps the count so icache stays at the front.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!icache_req)
      starve_nxt = '0;
    else if (grant_i) begin
      if (accepted)
        starve_nxt = '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT))
      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid           <= '0;
      owner_icache    <= '0;
      starve_cnt      <= '0;
      outstanding_cnt <= '0;
      orphan_err      <= 1'b0;
    end else begin
      valid           <= valid_nxt;
      owner_icache    <= owner_icache_nxt;
      starve_cnt      <= starve_nxt;
      outstanding_cnt <= cnt_nxt;
      orphan_err      <= orphan_nxt;
    end
  end

endmodule
